// File: rtl/pwr_save_seq_if.sv
// Interface bundle for the wrapper-bank power sequencer.
// Carries the sleep/wake requests, the save-area base address and wrapper
// contents, the single-word memory write handshake, the restore-unit enables,
// and the power/freeze/status outputs.
// Modports:
//   master - the sequencer (drives WriteMem/AddrMem/DataMem, Freeze, Pwr_off,
//            Start, Busy, Err)
//   slave  - the environment (memory, wrappers, restore unit, power control)
interface pwr_save_seq_if #(
    parameter int unsigned N = 10,
    parameter int unsigned K = 32,
    parameter int unsigned M = 32
);
    logic           SleepReq;
    logic           WakeReq;
    logic [K-1:0]   BaseAddr;
    logic [N*M-1:0] SaveVal;
    logic           AckMem;
    logic [N-1:0]   RestoreEn;
    logic           WriteMem;
    logic [K-1:0]   AddrMem;
    logic [M-1:0]   DataMem;
    logic           Freeze;
    logic           Pwr_off;
    logic           Start;
    logic           Busy;
    logic           Err;

    modport master (
        input  SleepReq, WakeReq, BaseAddr, SaveVal, AckMem, RestoreEn,
        output WriteMem, AddrMem, DataMem, Freeze, Pwr_off, Start, Busy, Err
    );

    modport slave (
        output SleepReq, WakeReq, BaseAddr, SaveVal, AckMem, RestoreEn,
        input  WriteMem, AddrMem, DataMem, Freeze, Pwr_off, Start, Busy, Err
    );
endinterface

// File: rtl/pwr_save_seq.sv
// Power-down/power-up sequencer for the IC wrapper bank.
// On SleepReq it freezes the wrappers, writes the N wrapper words to
// BaseAddr+i one at a time (one idle cycle between writes), then gates power.
// On WakeReq it restores power, pulses Start to the restore unit and waits for
// the last wrapper enable before returning to ACTIVE. A write that is not
// acknowledged within TMO cycles aborts the save and sets the sticky Err flag.
// Ports:
//   Clk - system clock, rising edge
//   Rst - asynchronous active-low reset
//   bus - pwr_save_seq_if.master (requests, memory write handshake, outputs)
module pwr_save_seq #(
    parameter int unsigned N   = 10,
    parameter int unsigned K   = 32,
    parameter int unsigned M   = 32,
    parameter int unsigned TMO = 255
) (
    input logic            Clk,
    input logic            Rst,
    pwr_save_seq_if.master bus
);
    localparam int unsigned IdxW = $clog2(N);
    localparam int unsigned TmoW = $clog2(TMO + 1);

    typedef enum logic [2:0] {
        StActive,
        StSaveWr,
        StSaveGap,
        StOff,
        StWake,
        StRestore
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            err_q, err_d;
    logic [K-1:0]    addr_q, addr_d;
    logic [M-1:0]    data_q, data_d;
    logic            load;
    logic [IdxW-1:0] load_idx;

    // Next-state logic. Address/data are captured on entry to SAVE_WR so they
    // stay stable for the whole write even if BaseAddr/SaveVal move.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        load     = 1'b0;
        load_idx = idx_q;

        unique case (state_q)
            StActive: begin
                if (bus.SleepReq) begin
                    state_d  = StSaveWr;
                    idx_d    = '0;
                    tmo_d    = '0;
                    err_d    = 1'b0;
                    load     = 1'b1;
                    load_idx = '0;
                end
            end
            StSaveWr: begin
                if (bus.AckMem) begin
                    if (idx_q == IdxW'(N - 1)) begin
                        state_d = StOff;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StSaveGap;
                    end
                end else if (tmo_q == TmoW'(TMO - 1)) begin
                    // Final unacknowledged cycle: abort, power stays on.
                    state_d = StActive;
                    idx_d   = '0;
                    tmo_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StSaveGap: begin
                tmo_d    = '0;
                state_d  = StSaveWr;
                load     = 1'b1;
                load_idx = idx_q;
            end
            StOff: begin
                if (bus.WakeReq) begin
                    state_d = StWake;
                end
            end
            StWake: begin
                state_d = StRestore;
            end
            StRestore: begin
                if (bus.RestoreEn[N-1]) begin
                    state_d = StActive;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = StActive;
            end
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        if (load) begin
            // Index zero-extends to K bits; the sum wraps modulo 2^K.
            addr_d = bus.BaseAddr + K'(load_idx);
            data_d = bus.SaveVal[32'(load_idx) * M +: M];
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= StActive;
            idx_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Outputs decode straight from registered state so an asynchronous reset
    // clears them (power back on, wrappers unfrozen) in the same cycle.
    always_comb begin
        bus.WriteMem = 1'b0;
        bus.AddrMem  = '0;
        bus.DataMem  = '0;
        bus.Freeze   = 1'b0;
        bus.Pwr_off  = 1'b0;
        bus.Start    = 1'b0;
        bus.Busy     = (state_q != StActive);
        bus.Err      = err_q;

        unique case (state_q)
            StActive: begin
            end
            StSaveWr: begin
                bus.WriteMem = 1'b1;
                bus.Freeze   = 1'b1;
                bus.AddrMem  = addr_q;
                bus.DataMem  = data_q;
            end
            StSaveGap: begin
                bus.Freeze = 1'b1;
            end
            StOff: begin
                bus.Freeze  = 1'b1;
                bus.Pwr_off = 1'b1;
            end
            StWake: begin
                bus.Freeze = 1'b1;
                bus.Start  = 1'b1;
            end
            StRestore: begin
                bus.Freeze = 1'b1;
            end
            default: begin
            end
        endcase
    end
endmodule

// File: tb/tb_pwr_save_seq.sv
module tb_pwr_save_seq;
    localparam int unsigned N   = 10;
    localparam int unsigned K   = 32;
    localparam int unsigned M   = 32;
    localparam int unsigned TMO = 4;

    logic Clk;
    logic Rst;
    int   checks;
    int   errors;

    pwr_save_seq_if #(.N(N), .K(K), .M(M)) bus ();

    pwr_save_seq #(.N(N), .K(K), .M(M), .TMO(TMO)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_reset();
        Rst = 1'b0;
        #1;
        Rst = 1'b1;
    endtask

    // Expects SAVE_WR for word 0 already presented; ends in OFF.
    task automatic run_save(input logic [31:0] base, input int wt, input bit gap_ack);
        logic [31:0] exp_a;
        logic [31:0] exp_d;
        for (int i = 0; i < int'(N); i++) begin
            exp_a = base + 32'(i);
            exp_d = 32'hA000_0000 + 32'(i);
            for (int c = 0; c <= wt; c++) begin
                checks++;
                if (bus.WriteMem !== 1'b1 || bus.AddrMem !== exp_a || bus.DataMem !== exp_d) begin
                    errors++;
                    $display("FAIL save_word%0d: got wr=%b addr=%h data=%h, want wr=1 addr=%h data=%h",
                             i, bus.WriteMem, bus.AddrMem, bus.DataMem, exp_a, exp_d);
                end
                checks++;
                if (bus.Pwr_off !== 1'b0 || bus.Freeze !== 1'b1) begin
                    errors++;
                    $display("FAIL save_pwr%0d: got pwr_off=%b freeze=%b, want 0/1",
                             i, bus.Pwr_off, bus.Freeze);
                end
                if (c == wt) bus.AckMem = 1'b1;
                tick();
            end
            if (i < int'(N) - 1) begin
                if (!gap_ack) bus.AckMem = 1'b0;
                checks++;
                if (bus.WriteMem !== 1'b0 || bus.Freeze !== 1'b1 || bus.Pwr_off !== 1'b0) begin
                    errors++;
                    $display("FAIL save_gap%0d: got wr=%b freeze=%b pwr_off=%b, want 0/1/0",
                             i, bus.WriteMem, bus.Freeze, bus.Pwr_off);
                end
                tick();
                bus.AckMem = 1'b0;
            end else begin
                bus.AckMem = 1'b0;
                checks++;
                if (bus.Pwr_off !== 1'b1 || bus.WriteMem !== 1'b0 || bus.Freeze !== 1'b1) begin
                    errors++;
                    $display("FAIL save_off: got pwr_off=%b wr=%b freeze=%b, want 1/0/1",
                             bus.Pwr_off, bus.WriteMem, bus.Freeze);
                end
            end
        end
    endtask

    // Expects OFF; ends in ACTIVE. keep_req leaves SleepReq/WakeReq high throughout.
    task automatic wake_restore(input bit keep_req);
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (bus.WriteMem !== 1'b0 || bus.Pwr_off !== 1'b1 || bus.Start !== 1'b0) begin
                errors++;
                $display("FAIL off_hold: got wr=%b pwr_off=%b start=%b, want 0/1/0",
                         bus.WriteMem, bus.Pwr_off, bus.Start);
            end
        end
        bus.WakeReq = 1'b1;
        tick();
        checks++;
        if (bus.Start !== 1'b1 || bus.Pwr_off !== 1'b0 || bus.Freeze !== 1'b1) begin
            errors++;
            $display("FAIL wake: got start=%b pwr_off=%b freeze=%b, want 1/0/1",
                     bus.Start, bus.Pwr_off, bus.Freeze);
        end
        if (!keep_req) bus.WakeReq = 1'b0;
        bus.RestoreEn = 10'h1FF;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (bus.Start !== 1'b0 || bus.Busy !== 1'b1 || bus.WriteMem !== 1'b0 ||
                bus.Pwr_off !== 1'b0 || bus.Freeze !== 1'b1) begin
                errors++;
                $display("FAIL restore_wait: got start=%b busy=%b wr=%b pwr_off=%b freeze=%b",
                         bus.Start, bus.Busy, bus.WriteMem, bus.Pwr_off, bus.Freeze);
            end
        end
        bus.RestoreEn = 10'h200;
        tick();
        bus.RestoreEn = '0;
        bus.WakeReq   = 1'b0;
        checks++;
        if (bus.Busy !== 1'b0 || bus.Freeze !== 1'b0 || bus.Start !== 1'b0) begin
            errors++;
            $display("FAIL restore_done: got busy=%b freeze=%b start=%b, want 0/0/0",
                     bus.Busy, bus.Freeze, bus.Start);
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        #1;
        Rst = 1'b0;
        #3;
        checks++;
        if ({bus.WriteMem, bus.Freeze, bus.Pwr_off, bus.Start, bus.Busy, bus.Err} !== 6'b0 ||
            bus.AddrMem !== 32'h0 || bus.DataMem !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got ctl=%b addr=%h data=%h, want 0",
                     {bus.WriteMem, bus.Freeze, bus.Pwr_off, bus.Start, bus.Busy, bus.Err},
                     bus.AddrMem, bus.DataMem);
        end
        @(negedge Clk);
        Rst = 1'b1;
        bus.WakeReq = 1'b1;
        tick();
        tick();
        bus.WakeReq = 1'b0;
        checks++;
        if (bus.Busy !== 1'b0 || bus.Start !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_wake: got busy=%b start=%b, want 0/0", bus.Busy, bus.Start);
        end
    endtask

    task automatic test_full_cycle();
        bus.BaseAddr = 32'h0000_1000;
        bus.SleepReq = 1'b1;
        tick();
        bus.SleepReq = 1'b0;
        checks++;
        if (bus.Busy !== 1'b1) begin
            errors++;
            $display("FAIL full_busy: got %b want 1", bus.Busy);
        end
        run_save(32'h0000_1000, 2, 1'b0);
        wake_restore(1'b0);
    endtask

    task automatic test_addr_wrap();
        bus.BaseAddr = 32'hFFFF_FFFE;
        bus.SleepReq = 1'b1;
        tick();
        bus.SleepReq = 1'b0;
        run_save(32'hFFFF_FFFE, 0, 1'b0);
        wake_restore(1'b0);
    endtask

    task automatic test_timeout();
        bus.BaseAddr = 32'h0000_3000;
        bus.SleepReq = 1'b1;
        tick();
        bus.SleepReq = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.AckMem = 1'b1;
            tick();
            bus.AckMem = 1'b0;
            tick();
        end
        checks++;
        if (bus.AddrMem !== 32'h0000_3003 || bus.WriteMem !== 1'b1) begin
            errors++;
            $display("FAIL tmo_word3: got addr=%h wr=%b, want 00003003/1", bus.AddrMem, bus.WriteMem);
        end
        for (int c = 1; c < int'(TMO); c++) begin
            tick();
            checks++;
            if (bus.WriteMem !== 1'b1 || bus.Err !== 1'b0 || bus.Pwr_off !== 1'b0) begin
                errors++;
                $display("FAIL tmo_wait%0d: got wr=%b err=%b pwr_off=%b, want 1/0/0",
                         c, bus.WriteMem, bus.Err, bus.Pwr_off);
            end
        end
        tick();
        checks++;
        if (bus.Err !== 1'b1 || bus.Busy !== 1'b0 || bus.WriteMem !== 1'b0 ||
            bus.Pwr_off !== 1'b0 || bus.Freeze !== 1'b0) begin
            errors++;
            $display("FAIL tmo_abort: got err=%b busy=%b wr=%b pwr_off=%b freeze=%b, want 1/0/0/0/0",
                     bus.Err, bus.Busy, bus.WriteMem, bus.Pwr_off, bus.Freeze);
        end
        tick();
        tick();
        checks++;
        if (bus.Err !== 1'b1 || bus.Pwr_off !== 1'b0) begin
            errors++;
            $display("FAIL tmo_sticky: got err=%b pwr_off=%b, want 1/0", bus.Err, bus.Pwr_off);
        end
        bus.SleepReq = 1'b1;
        tick();
        bus.SleepReq = 1'b0;
        checks++;
        if (bus.Err !== 1'b0 || bus.AddrMem !== 32'h0000_3000) begin
            errors++;
            $display("FAIL tmo_clear: got err=%b addr=%h, want 0/00003000", bus.Err, bus.AddrMem);
        end
        pulse_reset();
    endtask

    task automatic test_reset_mid_save();
        bus.BaseAddr = 32'h0000_1000;
        bus.SleepReq = 1'b1;
        tick();
        bus.SleepReq = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.AckMem = 1'b1;
            tick();
            bus.AckMem = 1'b0;
            tick();
        end
        checks++;
        if (bus.AddrMem !== 32'h0000_1005 || bus.DataMem !== 32'hA000_0005) begin
            errors++;
            $display("FAIL mid_word5: got addr=%h data=%h, want 00001005/a0000005",
                     bus.AddrMem, bus.DataMem);
        end
        #2;
        Rst = 1'b0;
        #1;
        checks++;
        if ({bus.WriteMem, bus.Freeze, bus.Pwr_off, bus.Start, bus.Busy, bus.Err} !== 6'b0 ||
            bus.AddrMem !== 32'h0 || bus.DataMem !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: got ctl=%b addr=%h data=%h, want 0",
                     {bus.WriteMem, bus.Freeze, bus.Pwr_off, bus.Start, bus.Busy, bus.Err},
                     bus.AddrMem, bus.DataMem);
        end
        bus.SleepReq = 1'b1;
        #1;
        Rst = 1'b1;
        tick();
        bus.SleepReq = 1'b0;
        checks++;
        if (bus.WriteMem !== 1'b1 || bus.AddrMem !== 32'h0000_1000 || bus.DataMem !== 32'hA000_0000) begin
            errors++;
            $display("FAIL mid_restart: got wr=%b addr=%h data=%h, want 1/00001000/a0000000",
                     bus.WriteMem, bus.AddrMem, bus.DataMem);
        end
        pulse_reset();
    endtask

    task automatic test_ignored_requests();
        bus.BaseAddr = 32'h0000_4000;
        bus.WakeReq  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (bus.Busy !== 1'b0 || bus.Start !== 1'b0) begin
                errors++;
                $display("FAIL active_wake: got busy=%b start=%b, want 0/0", bus.Busy, bus.Start);
            end
        end
        bus.WakeReq  = 1'b0;
        bus.SleepReq = 1'b1;
        tick();
        run_save(32'h0000_4000, 0, 1'b0);
        wake_restore(1'b1);
        bus.SleepReq = 1'b1;
        tick();
        checks++;
        if (bus.WriteMem !== 1'b1 || bus.AddrMem !== 32'h0000_4000) begin
            errors++;
            $display("FAIL resleep: got wr=%b addr=%h, want 1/00004000", bus.WriteMem, bus.AddrMem);
        end
        bus.SleepReq = 1'b0;
        pulse_reset();
    endtask

    task automatic test_gap_ack();
        bus.BaseAddr = 32'h0000_2000;
        bus.SleepReq = 1'b1;
        tick();
        bus.SleepReq = 1'b0;
        run_save(32'h0000_2000, 0, 1'b1);
        wake_restore(1'b0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        Rst           = 1'b1;
        bus.SleepReq  = 1'b0;
        bus.WakeReq   = 1'b0;
        bus.BaseAddr  = '0;
        bus.AckMem    = 1'b0;
        bus.RestoreEn = '0;
        for (int i = 0; i < int'(N); i++) begin
            bus.SaveVal[i*M +: M] = 32'hA000_0000 + 32'(i);
        end

        test_reset();
        test_full_cycle();
        test_addr_wrap();
        test_timeout();
        test_reset_mid_save();
        test_ignored_requests();
        test_gap_ack();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pwr_save_seq.md
Name: pwr_save_seq

Overview:
- Power-down/power-up sequencer for the IC wrapper bank.
- On a sleep request it freezes the wrappers and writes all N wrapper words to memory at BaseAddr+i through a single-word write handshake.
- It then asserts Pwr_off and waits for wake.
- On wake it drops Pwr_off, pulses Start to the restore control unit, and waits until the last wrapper (index N-1) has been restored.

Parameters:
- N, 10: number of IC wrappers (N>=2).
- K, 32: memory address width.
- M, 32: wrapper/memory data width.
- TMO, 255: max cycles to wait for AckMem per write word before abort (>=1).

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- SleepReq  in  1  request power-down (level, sampled in ACTIVE only).
- WakeReq  in  1  request power-up (level, sampled in OFF only).
- BaseAddr  in  K  base address of save area (same value given to restore unit).
- SaveVal  in  N*M  flattened wrapper contents; word i = SaveVal[i*M +: M].
- AckMem  in  1  single-cycle memory write acknowledge.
- RestoreEn  in  N  restore-unit wrapper enables; bit N-1 high = final word restored.
- WriteMem  out  1  memory write request.
- AddrMem  out  K  write address.
- DataMem  out  M  write data.
- Freeze  out  1  wrappers must hold value.
- Pwr_off  out  1  wrapper power gate (1 = off).
- Start  out  1  one-cycle start pulse to restore unit.
- Busy  out  1  high in every state except ACTIVE.
- Err  out  1  sticky save-timeout flag.

Behaviour:
- Reset (Rst=0, async): state ACTIVE, idx=0, tmo_cnt=0. All outputs 0; AddrMem and DataMem are 0.
- States: ACTIVE, SAVE_WR, SAVE_GAP, OFF, WAKE, RESTORE.
- ACTIVE:
  - Freeze=0.
  - SleepReq=1 -> SAVE_WR with idx=0, tmo_cnt=0, Err cleared.
  - WakeReq ignored.
- SAVE_WR:
  - Outputs: WriteMem=1, Freeze=1, AddrMem=BaseAddr+idx, DataMem=word idx.
  - Address arithmetic: idx zero-extended to K bits, sum modulo 2^K, no carry out.
  - AddrMem and DataMem are held stable while WriteMem=1.
  - AckMem=1 with idx<N-1 -> idx+1, go to SAVE_GAP.
  - AckMem=1 with idx=N-1 -> OFF.
  - tmo_cnt increments each cycle without ack. Reaching TMO -> Err=1, idx=0, ACTIVE. Save is aborted and Pwr_off is never asserted.
- SAVE_GAP:
  - WriteMem=0, Freeze=1 for exactly one cycle; tmo_cnt reset to 0.
  - Then -> SAVE_WR.
  - AckMem in this state is ignored.
- OFF:
  - Pwr_off=1, Freeze=1, WriteMem=0.
  - Earliest Pwr_off is the cycle after the N-th ack.
  - WakeReq=1 -> WAKE.
  - SleepReq ignored.
- WAKE:
  - Pwr_off=0, Freeze=1, Start=1 for exactly one cycle.
  - Then -> RESTORE.
- RESTORE:
  - Freeze=1, Pwr_off=0.
  - RestoreEn[N-1]=1 -> ACTIVE next cycle.
  - SleepReq and WakeReq ignored.
- Simultaneous SleepReq and WakeReq: only the request relevant to the current state is acted on.
- Total save latency with zero-wait ack (ack in first SAVE_WR cycle): 2N-1 cycles from entering SAVE_WR to OFF.
- Reset mid-operation: immediate return to reset values, including Pwr_off=0 (power restored) and Freeze=0. Saved memory contents are left as-is.
- Err persists until the next accepted SleepReq or reset.
- Busy = (state != ACTIVE).

Test Plan:
1. N=10, BaseAddr=0x1000, word i=0xA000_0000+i, AckMem 2 cycles after each WriteMem rise, then WakeReq. Required:
   - 10 writes at 0x1000..0x1009 with matching data and a 1-cycle WriteMem gap between writes.
   - Pwr_off=1 the cycle after the 10th ack; no more writes.
   - WakeReq -> one Start pulse; Pwr_off=0 on the Start cycle.
   - RestoreEn=0x200 -> Busy=0 and Freeze=0 next cycle.
2. BaseAddr=0xFFFF_FFFE, zero-wait ack -> addresses 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0, ..., 0x7.
3. TMO=4, ack withheld on word 3 -> Err=1 after 4 waiting cycles; state ACTIVE; Pwr_off never 1; Busy=0.
4. Rst low during SAVE_WR of word 5 -> same cycle: all outputs 0. After release with SleepReq=1, saving restarts at BaseAddr+0.
5. SleepReq held high during OFF and RESTORE, WakeReq high in ACTIVE -> no extra writes, no spurious Start. After return to ACTIVE with SleepReq still high, a new save begins next cycle.
6. AckMem pulsed during SAVE_GAP -> ignored; idx not advanced; each address written exactly once.
